config_regfile_apb: RTL and testbench

//  Next-generation configuration store: parametrised word/depth register file with a full APB3 slave
//  (PSEL/PENABLE/PREADY/PSLVERR, byte strobes, programmable wait states) and a system-side R/W port.

---
 rtl/config_regfile_apb_if.sv | 25 ++
 rtl/config_regfile_apb.sv | 118 +++++++++++
 tb/tb_config_regfile_apb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_regfile_apb_if.sv
// APB3 bus bundle for the configuration register file.
// The master drives the request fields; the slave returns read data, ready and error.
interface config_regfile_apb_if #(
  parameter int DW = 32
);
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [15:0]     paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/config_regfile_apb.sv
// Word/depth configuration register file with an APB3 slave (byte strobes, wait states)
// and a single-cycle system read/write port sharing the same storage.
module config_regfile_apb #(
  parameter int DW          = 32,
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int WAIT_STATES = 0
) (
  input  logic                 pclk,
  input  logic                 prst,
  config_regfile_apb_if.slave  apb,
  input  logic                 config_state_write_enable,
  input  logic                 sys_rd_en,
  input  logic                 sys_wr_en,
  input  logic [AW-1:0]        sys_addr,
  input  logic [DW-1:0]        sys_wdata,
  output logic [DW-1:0]        sys_rdata,
  output logic                 sys_rvalid,
  output logic                 sys_err
);

  localparam int              NB        = DW / 8;
  localparam logic [16:0]     DEPTH_APB = 17'(DEPTH);
  localparam logic [AW:0]     DEPTH_SYS = (AW + 1)'(DEPTH);
  localparam logic [3:0]      WS        = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_p0, state_nxt;
  logic [3:0]    cnt_p0, cnt_nxt;
  logic [DW-1:0] mem [DEPTH];

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [NB-1:0] strb);
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

  logic          apb_addr_ok;
  logic          apb_err;
  logic          apb_commit;
  logic [AW-1:0] apb_idx;

  assign apb_addr_ok = {1'b0, apb.paddr} < DEPTH_APB;
  assign apb_idx     = apb.paddr[AW-1:0];
  assign apb_err     = !apb_addr_ok || (apb.pwrite && !config_state_write_enable);

  // Stage p0: APB transfer FSM; pready is decoded from the current state and wait count
  always_comb begin
    state_nxt  = state_p0;
    cnt_nxt    = cnt_p0;
    apb.pready = 1'b0;
    case (state_p0)
      IDLE: begin
        if (apb.psel) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          state_nxt = IDLE;
        end else if (cnt_p0 < WS) begin
          cnt_nxt = cnt_p0 + 4'd1;
        end else if (apb.penable) begin
          apb.pready = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign apb.pslverr = apb.pready && apb_err;
  assign apb.prdata  = (apb.pready && !apb.pwrite && !apb_err) ? mem[apb_idx] : '0;
  assign apb_commit  = apb.pready && apb.pwrite && !apb_err;

  logic sys_addr_ok;
  logic sys_rd_ok;
  logic sys_wr_clash;
  logic sys_wr_ok;
  logic sys_drop;

  // An APB commit to the same word takes the whole word away from the system write.
  assign sys_addr_ok  = {1'b0, sys_addr} < DEPTH_SYS;
  assign sys_rd_ok    = sys_rd_en && sys_addr_ok;
  assign sys_wr_clash = apb_commit && (apb_idx == sys_addr);
  assign sys_wr_ok    = sys_wr_en && !sys_rd_en && sys_addr_ok && !sys_wr_clash;
  assign sys_drop     = ((sys_rd_en || sys_wr_en) && !sys_addr_ok)
                      || (sys_rd_en && sys_wr_en)
                      || (sys_wr_en && !sys_rd_en && sys_addr_ok && sys_wr_clash);

  // Stage p1: storage update and registered system response
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_p0   <= IDLE;
      cnt_p0     <= '0;
      sys_rdata  <= '0;
      sys_rvalid <= 1'b0;
      sys_err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_p0   <= state_nxt;
      cnt_p0     <= cnt_nxt;
      sys_rvalid <= sys_rd_ok;
      sys_err    <= sys_drop;
      if (sys_rd_ok)  sys_rdata     <= mem[sys_addr];
      if (sys_wr_ok)  mem[sys_addr] <= sys_wdata;
      if (apb_commit) mem[apb_idx]  <= merge_lanes(mem[apb_idx], apb.pwdata, apb.pstrb);
    end
  end

endmodule

// File: tb/tb_config_regfile_apb.sv
// Scoreboard bench: stimulus queues expected responses, monitors pop and compare them
// whenever a DUT presents pready or a system response pulse.
module tb_config_regfile_apb;

  logic pclk = 1'b0;
  logic prst = 1'b1;
  always #5 pclk = ~pclk;

  config_regfile_apb_if #(.DW(32)) bus0 ();
  config_regfile_apb_if #(.DW(32)) bus1 ();

  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, tgt = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        cfg_we = 1'b0;
  logic        sys_rd_en = 1'b0, sys_wr_en = 1'b0;
  logic [5:0]  sys_addr = '0;
  logic [31:0] sys_wdata = '0;
  logic [31:0] sys_rdata, sys1_rdata;
  logic        sys_rvalid, sys_err, sys1_rvalid, sys1_err;

  assign bus0.psel = psel && !tgt;
  assign bus1.psel = psel && tgt;
  assign bus0.penable = penable;
  assign bus1.penable = penable;
  assign bus0.pwrite = pwrite;
  assign bus1.pwrite = pwrite;
  assign bus0.paddr = paddr;
  assign bus1.paddr = paddr;
  assign bus0.pwdata = pwdata;
  assign bus1.pwdata = pwdata;
  assign bus0.pstrb = pstrb;
  assign bus1.pstrb = pstrb;

  config_regfile_apb #(.DW(32), .DEPTH(64), .AW(6), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .prst(prst), .apb(bus0.slave),
    .config_state_write_enable(cfg_we),
    .sys_rd_en(sys_rd_en), .sys_wr_en(sys_wr_en), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_rdata(sys_rdata), .sys_rvalid(sys_rvalid), .sys_err(sys_err)
  );

  config_regfile_apb #(.DW(32), .DEPTH(64), .AW(6), .WAIT_STATES(3)) dut1 (
    .pclk(pclk), .prst(prst), .apb(bus1.slave),
    .config_state_write_enable(cfg_we),
    .sys_rd_en(1'b0), .sys_wr_en(1'b0), .sys_addr(6'd0), .sys_wdata(32'd0),
    .sys_rdata(sys1_rdata), .sys_rvalid(sys1_rvalid), .sys_err(sys1_err)
  );

  logic rdy_sel;
  assign rdy_sel = tgt ? bus1.pready : bus0.pready;

  typedef struct packed { logic [31:0] rdata; logic err; } apb_exp_t;
  typedef struct packed { logic [31:0] rdata; logic v; logic e; } sys_exp_t;
  apb_exp_t apb_q[$];
  sys_exp_t sys_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic check_apb(input string nm, input logic [31:0] rd, input logic er);
    apb_exp_t e;
    if (apb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_unexpected_pready: got pready=1 want no transfer", nm);
    end else begin
      e = apb_q.pop_front();
      chk({nm, "_prdata"}, rd, e.rdata);
      chk1({nm, "_pslverr"}, er, e.err);
    end
  endtask

  always @(negedge pclk) begin
    if (bus0.pready) check_apb("apb0", bus0.prdata, bus0.pslverr);
    if (bus1.pready) check_apb("apb1", bus1.prdata, bus1.pslverr);
    if (sys_rvalid || sys_err) begin
      if (sys_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sys_unexpected: got rvalid=%b err=%b want none", sys_rvalid, sys_err);
      end else begin
        sys_exp_t s;
        s = sys_q.pop_front();
        chk("sys_rdata", sys_rdata, s.rdata);
        chk1("sys_rvalid", sys_rvalid, s.v);
        chk1("sys_err", sys_err, s.e);
      end
    end
    if (sys1_rvalid || sys1_err) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sys1_unexpected: got rvalid=%b err=%b want none", sys1_rvalid, sys1_err);
    end
  end

  task automatic apb_xfer(input logic t, input logic wr, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    apb_exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    apb_q.push_back(e);
    @(posedge pclk); #1;
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    lat = 1;
    @(posedge pclk); #1;
    penable = 1'b1;
    lat = 2;
    forever begin
      @(negedge pclk);
      if (rdy_sel) break;
      if (lat >= 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL apb_timeout: got no pready after %0d cycles want %0d", lat, exp_lat);
        break;
      end
      @(posedge pclk); #1;
      lat++;
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("apb_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic sys_op(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d,
                        input logic exp_v, input logic exp_e, input logic [31:0] exp_rd);
    sys_exp_t s;
    if (exp_v || exp_e) begin
      s.rdata = exp_rd; s.v = exp_v; s.e = exp_e;
      sys_q.push_back(s);
    end
    @(posedge pclk); #1;
    sys_rd_en = rd; sys_wr_en = wr; sys_addr = a; sys_wdata = d;
    @(posedge pclk); #1;
    sys_rd_en = 1'b0; sys_wr_en = 1'b0;
  endtask

  // System request presented in the same cycle as the APB pready cycle (WAIT_STATES=0 DUT).
  task automatic collide(input logic [15:0] aa, input logic [31:0] ad,
                         input logic srd, input logic swr, input logic [5:0] sa, input logic [31:0] sd,
                         input logic exp_v, input logic exp_e, input logic [31:0] exp_rd);
    sys_exp_t s;
    if (exp_v || exp_e) begin
      s.rdata = exp_rd; s.v = exp_v; s.e = exp_e;
      sys_q.push_back(s);
    end
    fork
      apb_xfer(1'b0, 1'b1, aa, ad, 4'hF, 32'h0, 1'b0, 2);
      begin
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        sys_rd_en = srd; sys_wr_en = swr; sys_addr = sa; sys_wdata = sd;
        @(posedge pclk); #1;
        sys_rd_en = 1'b0; sys_wr_en = 1'b0;
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prst = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk1("rst_pready0", bus0.pready, 1'b0);
    chk1("rst_pslverr0", bus0.pslverr, 1'b0);
    chk("rst_prdata0", bus0.prdata, 32'h0);
    chk("rst_sys_rdata", sys_rdata, 32'h0);
    chk1("rst_sys_rvalid", sys_rvalid, 1'b0);
    chk1("rst_sys_err", sys_err, 1'b0);
    chk1("rst_pready1", bus1.pready, 1'b0);
    @(posedge pclk); #1;
    prst = 1'b0;

    apb_xfer(1'b0, 1'b0, 16'd5, 32'h0, 4'h0, 32'h0, 1'b0, 2);

    cfg_we = 1'b1;
    apb_xfer(1'b0, 1'b1, 16'd3, 32'hA5A5_5A5A, 4'b0101, 32'h0, 1'b0, 2);
    sys_op(1'b1, 1'b0, 6'd3, 32'h0, 1'b1, 1'b0, 32'h00A5_005A);

    cfg_we = 1'b0;
    apb_xfer(1'b0, 1'b1, 16'd3, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 2);
    sys_op(1'b1, 1'b0, 6'd3, 32'h0, 1'b1, 1'b0, 32'h00A5_005A);
    cfg_we = 1'b1;
    apb_xfer(1'b0, 1'b1, 16'd64, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 2);
    apb_xfer(1'b0, 1'b0, 16'd64, 32'h0, 4'h0, 32'h0, 1'b1, 2);
    apb_xfer(1'b0, 1'b1, 16'd3, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 2);
    apb_xfer(1'b0, 1'b0, 16'd3, 32'h0, 4'h0, 32'h00A5_005A, 1'b0, 2);
    apb_xfer(1'b0, 1'b1, 16'd3, 32'h1234_5678, 4'b1000, 32'h0, 1'b0, 2);
    apb_xfer(1'b0, 1'b0, 16'd3, 32'h0, 4'h0, 32'h12A5_005A, 1'b0, 2);

    apb_xfer(1'b1, 1'b0, 16'd0, 32'h0, 4'h0, 32'h0, 1'b0, 5);
    apb_xfer(1'b1, 1'b1, 16'd1, 32'hCAFE_BABE, 4'hF, 32'h0, 1'b0, 5);
    apb_xfer(1'b1, 1'b0, 16'd1, 32'h0, 4'h0, 32'hCAFE_BABE, 1'b0, 5);
    @(posedge pclk); #1;
    tgt = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd1;
    pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      chk1("abort_no_pready", bus1.pready, 1'b0);
    end
    apb_xfer(1'b1, 1'b0, 16'd1, 32'h0, 4'h0, 32'hCAFE_BABE, 1'b0, 5);

    sys_op(1'b0, 1'b1, 6'd7, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
    sys_op(1'b1, 1'b1, 6'd7, 32'hDEAD_0000, 1'b1, 1'b1, 32'h7777_7777);
    sys_op(1'b1, 1'b0, 6'd7, 32'h0, 1'b1, 1'b0, 32'h7777_7777);
    collide(16'd9, 32'h1111_1111, 1'b0, 1'b1, 6'd9, 32'h2222_2222, 1'b0, 1'b1, 32'h7777_7777);
    sys_op(1'b1, 1'b0, 6'd9, 32'h0, 1'b1, 1'b0, 32'h1111_1111);
    collide(16'd9, 32'h3333_3333, 1'b1, 1'b0, 6'd9, 32'h0, 1'b1, 1'b0, 32'h1111_1111);
    sys_op(1'b1, 1'b0, 6'd9, 32'h0, 1'b1, 1'b0, 32'h3333_3333);
    collide(16'd10, 32'hAAAA_5555, 1'b0, 1'b1, 6'd11, 32'hBBBB_0000, 1'b0, 1'b0, 32'h0);
    sys_op(1'b1, 1'b0, 6'd10, 32'h0, 1'b1, 1'b0, 32'hAAAA_5555);
    sys_op(1'b1, 1'b0, 6'd11, 32'h0, 1'b1, 1'b0, 32'hBBBB_0000);

    @(posedge pclk); #1;
    tgt = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd1;
    pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk1("rst2_pready1", bus1.pready, 1'b0);
    chk1("rst2_pslverr1", bus1.pslverr, 1'b0);
    chk("rst2_prdata1", bus1.prdata, 32'h0);
    chk("rst2_sys_rdata", sys_rdata, 32'h0);
    chk1("rst2_sys_rvalid", sys_rvalid, 1'b0);
    chk1("rst2_sys_err", sys_err, 1'b0);
    apb_xfer(1'b1, 1'b0, 16'd1, 32'h0, 4'h0, 32'h0, 1'b0, 5);
    sys_op(1'b1, 1'b0, 6'd11, 32'h0, 1'b1, 1'b0, 32'h0);

    repeat (3) @(negedge pclk);
    chk("apb_queue_drained", 32'(apb_q.size()), 32'h0);
    chk("sys_queue_drained", 32'(sys_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
